uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_baud_edge_sync.sv | 27 ++
 rtl/uart_tx.sv | 150 +++++++++++++++
 tb/tb_uart_tx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and width helpers for the transmitter and future receiver.
// Parity support is compiled in with UART_TX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    function automatic int bit_idx_w(input int data_bits);
        return (data_bits > 1) ? $clog2(data_bits) : 1;
    endfunction

    function automatic int stop_cnt_w(input int stop_bits);
        return (stop_bits > 1) ? $clog2(stop_bits) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_baud_edge_sync.sv
// Two-flop synchronizer for the baud clock plus a rising-edge detector.
// Produces a one-cycle tick per baud rising edge; shared with the receiver.
module baud_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic baud_i,
    output logic tick_o
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], baud_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign tick_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/uart_tx.sv
// UART serializer with a one-entry holding register, driven by baud ticks.
// Define UART_TX_PARITY_EN to add a parity bit after the data bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 SysClk,
    input  logic                 Rst_n,
    input  logic                 BaudClk,
    input  logic [DATA_BITS-1:0] TxData,
    input  logic                 TxValid,
    output logic                 TxReady,
    output logic                 Tx,
    output logic                 TxBusy
);

    localparam int IW = bit_idx_w(DATA_BITS);
    localparam int SW = stop_cnt_w(STOP_BITS);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
    localparam logic [SW-1:0] LAST_STOP = SW'(STOP_BITS - 1);

    logic                 tick;
    logic                 load;
    logic                 accept;
    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [SW-1:0]        stop_q, stop_d;
    logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    localparam logic ODD = (PARITY_ODD != 0);
    logic                 par_q, par_d;
`endif

    baud_edge_sync u_sync (
        .clk    (SysClk),
        .rst_n  (Rst_n),
        .baud_i (BaudClk),
        .tick_o (tick)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        stop_d      = stop_q;
        load        = 1'b0;
        accept      = TxValid & ~hold_full_q;
`ifdef UART_TX_PARITY_EN
        par_d       = par_q;
`endif
        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    load = hold_full_q;
                end
                ST_START: begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
                ST_DATA: begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        stop_d  = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    state_d = ST_STOP;
                    stop_d  = '0;
                end
`endif
                ST_STOP: begin
                    if (stop_q == LAST_STOP) begin
                        // a queued character follows the stop bit with no idle gap
                        if (hold_full_q) load = 1'b1;
                        else state_d = ST_IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (load) begin
            shift_d     = hold_q;
            state_d     = ST_START;
            hold_full_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d       = (^hold_q) ^ ODD;
`endif
        end
        if (accept) begin
            hold_d      = TxData;
            hold_full_d = 1'b1;
        end
        case (state_d)
            ST_START:  tx_d = LINE_START;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:   tx_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge SysClk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            idx_q       <= '0;
            stop_q      <= '0;
            tx_q        <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            stop_q      <= stop_d;
            tx_q        <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign TxReady = ~hold_full_q;
    assign Tx      = tx_q;
    assign TxBusy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 8-bit/1-stop and 8-bit/2-stop instances.
// Frame expectations follow the parity macro when it is defined.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LEN1 = 10 + PAR;
    localparam int LEN2 = 11 + PAR;

    logic       SysClk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       BaudClk = 1'b0;
    logic [7:0] data1 = '0;
    logic [7:0] data2 = '0;
    logic       valid1 = 1'b0;
    logic       valid2 = 1'b0;
    logic       ready1, ready2, tx1, tx2, busy1, busy2;
    int         cmp_cnt = 0;
    int         fail_cnt = 0;
    logic [63:0] t, b, e;

    uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut1 (
        .SysClk(SysClk), .Rst_n(Rst_n), .BaudClk(BaudClk),
        .TxData(data1), .TxValid(valid1), .TxReady(ready1),
        .Tx(tx1), .TxBusy(busy1)
    );

    uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) u_dut2 (
        .SysClk(SysClk), .Rst_n(Rst_n), .BaudClk(BaudClk),
        .TxData(data2), .TxValid(valid2), .TxReady(ready2),
        .Tx(tx2), .TxBusy(busy2)
    );

    always #5 SysClk = ~SysClk;

    initial begin
        #2;
        forever #80 BaudClk = ~BaudClk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // bit i of the result is the line level during tick period i
    function automatic logic [63:0] frame(input logic [7:0] d,
                                          input int stops, input bit odd);
        logic [63:0] f;
        int p;
        f = '0;
        p = 1;
        for (int i = 0; i < 8; i++) begin
            f[p] = d[i];
            p++;
        end
        if (PAR == 1) begin
            f[p] = (^d) ^ odd;
            p++;
        end
        for (int s = 0; s < stops; s++) begin
            f[p] = 1'b1;
            p++;
        end
        return f;
    endfunction

    task automatic align();
        @(negedge BaudClk);
        #1;
    endtask

    task automatic push(input int which, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge SysClk);
        if (which == 0) begin
            data1 = d;
            valid1 = 1'b1;
        end else begin
            data2 = d;
            valid2 = 1'b1;
        end
        while (((which == 0) ? ready1 : ready2) !== 1'b1 && n < 5000) begin
            @(negedge SysClk);
            n++;
        end
        check("push_wait", 64'(n >= 5000), 64'd0);
        @(posedge SysClk);
        #1;
        if (which == 0) valid1 = 1'b0;
        else valid2 = 1'b0;
    endtask

    task automatic capture(input int which, input int n,
                           output logic [63:0] tv, output logic [63:0] bv);
        tv = '0;
        bv = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge BaudClk);
            #1;
            tv[i] = (which == 0) ? tx1 : tx2;
            bv[i] = (which == 0) ? busy1 : busy2;
        end
    endtask

    initial begin
        logic [7:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};

        repeat (3) @(posedge SysClk);
        #1;
        check("rst_tx", tx1, 1);
        check("rst_ready", ready1, 1);
        check("rst_busy", busy1, 0);
        check("rst_tx2", tx2, 1);
        Rst_n = 1'b1;

        // single frame 0xA5 from idle
        align();
        push(0, 8'hA5);
        check("a5_rdy_drop", ready1, 0);
        @(posedge BaudClk);
        repeat (2) @(posedge SysClk);
        #1;
        check("a5_rdy_tick", ready1, 0);
        check("a5_busy_tick", busy1, 0);
        @(posedge SysClk);
        #1;
        check("a5_rdy_free", ready1, 1);
        check("a5_busy_on", busy1, 1);
        check("a5_start", tx1, 0);
        capture(0, LEN1 + 1, t, b);
        check("a5_frame", t, frame(8'hA5, 1, 1'b0) | (64'd1 << LEN1));
        check("a5_busy", b, (64'd1 << LEN1) - 1);
`ifndef UART_TX_PARITY_EN
        check("a5_literal", {54'd0, t[9:0]}, 64'h34A);
`endif

        // back-to-back 0xFF then 0x00, with ignored valid while full
        align();
        push(0, 8'hFF);
        fork
            capture(0, 2 * LEN1 + 1, t, b);
            begin
                push(0, 8'h00);
                repeat (3) begin
                    @(negedge SysClk);
                    data1 = 8'h55;
                    valid1 = 1'b1;
                end
                @(negedge SysClk);
                valid1 = 1'b0;
            end
        join
        e = frame(8'hFF, 1, 1'b0) | (frame(8'h00, 1, 1'b0) << LEN1)
          | (64'd1 << (2 * LEN1));
        check("b2b_frame", t, e);
        check("b2b_busy", b, (64'd1 << (2 * LEN1)) - 1);
        check("b2b_ready", ready1, 1);

        // valid held high across four characters
        align();
        fork
            capture(0, 4 * LEN1 + 1, t, b);
            begin
                for (int k = 0; k < 4; k++) begin
                    int n;
                    n = 0;
                    @(negedge SysClk);
                    data1 = vals[k];
                    valid1 = 1'b1;
                    while (ready1 !== 1'b1 && n < 5000) begin
                        @(negedge SysClk);
                        n++;
                    end
                    check("stream_wait", 64'(n >= 5000), 64'd0);
                    @(posedge SysClk);
                    #1;
                end
                valid1 = 1'b0;
            end
        join
        e = 64'd1 << (4 * LEN1);
        for (int k = 0; k < 4; k++) e = e | (frame(vals[k], 1, 1'b0) << (k * LEN1));
        check("stream_frame", t, e);
        check("stream_busy", b, (64'd1 << (4 * LEN1)) - 1);

        // reset during data bit 3 with a character queued
        align();
        push(0, 8'hF0);
        capture(0, 1, t, b);
        push(0, 8'h99);
        capture(0, 4, t, b);
        check("rst_pre_bits", t, 64'h0);
        check("rst_pre_busy", b, 64'hF);
        Rst_n = 1'b0;
        #1;
        check("rst_async_tx", tx1, 1);
        repeat (3) @(posedge SysClk);
        #1;
        Rst_n = 1'b1;
        #1;
        check("rst_rel_ready", ready1, 1);
        check("rst_rel_busy", busy1, 0);
        check("rst_rel_tx", tx1, 1);
        align();
        push(0, 8'h3C);
        capture(0, LEN1 + 2, t, b);
        check("post_rst_frame", t, frame(8'h3C, 1, 1'b0) | (64'd3 << LEN1));
        check("post_rst_busy", b, (64'd1 << LEN1) - 1);

        // two stop bits
        align();
        push(1, 8'h81);
        capture(1, LEN2 + 1, t, b);
        check("stop2_frame", t, frame(8'h81, 2, 1'b1) | (64'd1 << LEN2));
        check("stop2_busy", b, (64'd1 << LEN2) - 1);

        // 0x07: even parity on instance 1, odd on instance 2
        align();
        push(0, 8'h07);
        capture(0, LEN1 + 1, t, b);
        check("p07_even_frame", t, frame(8'h07, 1, 1'b0) | (64'd1 << LEN1));
`ifdef UART_TX_PARITY_EN
        check("p07_even_bit", t[9], 1);
`endif
        align();
        push(1, 8'h07);
        capture(1, LEN2 + 1, t, b);
        check("p07_odd_frame", t, frame(8'h07, 2, 1'b1) | (64'd1 << LEN2));
`ifdef UART_TX_PARITY_EN
        check("p07_odd_bit", t[9], 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
